dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl.sv | 135 +++++++++++++
 tb/tb_dmem_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Single-port data memory controller: byte/half/word/dword loads and stores.
// Response READ_LAT cycles after acceptance; one access in flight, req_ready only in IDLE.
module dmem_ctrl #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 1024,
    parameter int ADDR_W   = 12,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);
    localparam int BYTES  = DATA_W / 8;
    localparam int OFF_W  = $clog2(BYTES);
    localparam int IDX_W  = ADDR_W - OFF_W;
    localparam int MEM_AW = $clog2(DEPTH);
    localparam logic [2:0] LAT_M1 = 3'(READ_LAT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [2:0]        r_cnt;
    logic              r_live;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [OFF_W-1:0]  w_off;
    logic [IDX_W-1:0]  w_idx;
    logic              w_acc;
    logic              w_mis;
    logic              w_oob;
    logic              w_err;
    logic [BYTES-1:0]  w_bsz;
    logic [BYTES-1:0]  w_bmask;
    logic [DATA_W-1:0] w_wsh;
    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] w_shr;
    logic [DATA_W-1:0] w_lmask;
    logic              w_msb;
    logic [DATA_W-1:0] w_ldata;

    assign w_off   = req_addr[OFF_W-1:0];
    assign w_idx   = req_addr[ADDR_W-1:OFF_W];
    assign w_acc   = req_valid && req_ready;
    assign w_oob   = {1'b0, w_idx} >= (IDX_W + 1)'(DEPTH);
    assign w_err   = w_mis || w_oob || ((req_size == 2'b11) && (DATA_W == 32));
    assign w_bmask = w_bsz << w_off;
    assign w_wsh   = req_wdata << {w_off, 3'b000};
    assign w_word  = r_mem[w_idx[MEM_AW-1:0]];
    assign w_shr   = w_word >> {w_off, 3'b000};
    assign w_ldata = (w_shr & w_lmask) | ((req_signed && w_msb) ? ~w_lmask : '0);

    always_comb begin
        w_mis   = 1'b0;
        w_bsz   = '1;
        w_lmask = '1;
        w_msb   = w_shr[DATA_W-1];
        case (req_size)
            2'b00: begin
                w_bsz   = BYTES'(1);
                w_lmask = DATA_W'(32'h0000_00FF);
                w_msb   = w_shr[7];
            end
            2'b01: begin
                w_mis   = req_addr[0];
                w_bsz   = BYTES'(3);
                w_lmask = DATA_W'(32'h0000_FFFF);
                w_msb   = w_shr[15];
            end
            2'b10: begin
                w_mis   = |req_addr[1:0];
                w_bsz   = BYTES'(15);
                w_lmask = DATA_W'(32'hFFFF_FFFF);
                w_msb   = w_shr[31];
            end
            default: w_mis = |req_addr[2:0];
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_acc) w_next = (READ_LAT == 1) ? RESP : WAIT;
            WAIT:    if (r_cnt == 3'd1) w_next = RESP;
            RESP:    if (resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Load data and error are resolved at acceptance, so RESP just replays them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_live  <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
            if (w_acc) begin
                r_cnt   <= LAT_M1;
                r_err   <= w_err;
                r_rdata <= (req_we || w_err) ? '0 : w_ldata;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc && req_we && !w_err) begin
            for (int b = 0; b < BYTES; b++) begin
                if (w_bmask[b]) r_mem[w_idx[MEM_AW-1:0]][8*b +: 8] <= w_wsh[8*b +: 8];
            end
        end
    end

    assign req_ready  = r_live && (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign resp_rdata = resp_valid ? r_rdata : '0;
    assign resp_err   = resp_valid && r_err;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: one instance at READ_LAT=1 and one at READ_LAT=3, selected by sel.
module tb_dmem_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        req_valid;
    logic        req_we;
    logic [12:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_wdata;
    logic        resp_ready;

    logic        a_req_ready, a_resp_valid, a_resp_err;
    logic [31:0] a_resp_rdata;
    logic        b_req_ready, b_resp_valid, b_resp_err;
    logic [31:0] b_resp_rdata;
    logic        a_req_valid, b_req_valid, a_resp_ready, b_resp_ready;
    logic        m_req_ready, m_resp_valid, m_resp_err;
    logic [31:0] m_resp_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    logic [32:0] sb_q [$];

    always #5 clk = ~clk;

    assign a_req_valid  = req_valid && !sel;
    assign b_req_valid  = req_valid && sel;
    assign a_resp_ready = resp_ready && !sel;
    assign b_resp_ready = resp_ready && sel;
    assign m_req_ready  = sel ? b_req_ready  : a_req_ready;
    assign m_resp_valid = sel ? b_resp_valid : a_resp_valid;
    assign m_resp_err   = sel ? b_resp_err   : a_resp_err;
    assign m_resp_rdata = sel ? b_resp_rdata : a_resp_rdata;

    dmem_ctrl #(.DATA_W(32), .DEPTH(1024), .ADDR_W(13), .READ_LAT(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata), .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
    );

    dmem_ctrl #(.DATA_W(32), .DEPTH(1024), .ADDR_W(13), .READ_LAT(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata), .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic access(input string tag, input logic we, input logic [12:0] addr,
                          input logic [1:0] size, input logic sgn, input logic [31:0] wd,
                          input logic exp_err, input logic [31:0] exp_rd, input int hold);
        logic        got;
        logic        seen;
        int          c;
        int          lat;
        logic [32:0] cap;
        logic [32:0] exp;
        sb_q.push_back({exp_err, exp_rd});
        lat = sel ? 3 : 1;
        @(negedge clk);
        req_we = we; req_addr = addr; req_size = size; req_signed = sgn; req_wdata = wd;
        req_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (m_req_ready) got = 1'b1;
            else @(negedge clk);
        end
        chk({tag, "_accept"}, 64'(got), 64'd1);
        if (!got) begin
            req_valid = 1'b0;
            void'(sb_q.pop_front());
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        c = 0;
        seen = 1'b0;
        while (c < 10 && !seen) begin
            @(negedge clk);
            c++;
            seen = m_resp_valid;
        end
        chk({tag, "_latency"}, 64'(c), 64'(lat));
        if (!seen) begin
            void'(sb_q.pop_front());
            return;
        end
        cap = {m_resp_err, m_resp_rdata};
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 64'(m_resp_valid), 64'd1);
            chk({tag, "_hold_data"}, 64'({m_resp_err, m_resp_rdata}), 64'(cap));
            chk({tag, "_hold_req_ready"}, 64'(m_req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        chk({tag, "_ready_in_resp"}, 64'(m_req_ready), 64'd0);
        exp = sb_q.pop_front();
        chk({tag, "_err_rdata"}, 64'({m_resp_err, m_resp_rdata}), 64'(exp));
        @(posedge clk);
        #1 resp_ready = 1'b0;
        chk({tag, "_ready_after"}, 64'(m_req_ready), 64'd1);
        chk({tag, "_valid_drop"}, 64'(m_resp_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_size = 2'b00; req_signed = 1'b0; req_wdata = '0; resp_ready = 1'b0;
        #12;
        chk("rst_req_ready", 64'(a_req_ready), 64'd0);
        chk("rst_resp_valid", 64'(a_resp_valid), 64'd0);
        chk("rst_resp_rdata", 64'({a_resp_err, a_resp_rdata}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready_a", 64'(a_req_ready), 64'd1);
        chk("post_rst_ready_b", 64'(b_req_ready), 64'd1);

        access("st_word",   1, 13'h010, 2'b10, 0, 32'hDEADBEEF, 0, 32'h0, 0);
        access("ld_word",   0, 13'h010, 2'b10, 0, 32'h0, 0, 32'hDEADBEEF, 0);
        access("st_byte",   1, 13'h013, 2'b00, 0, 32'h12345680, 0, 32'h0, 0);
        access("ld_byte_s", 0, 13'h013, 2'b00, 1, 32'h0, 0, 32'hFFFFFF80, 0);
        access("ld_byte_u", 0, 13'h013, 2'b00, 0, 32'h0, 0, 32'h00000080, 0);
        access("ld_word2",  0, 13'h010, 2'b10, 0, 32'h0, 0, 32'h80ADBEEF, 0);
        access("ld_half_mis", 0, 13'h011, 2'b01, 0, 32'h0, 1, 32'h0, 0);
        access("ld_word3",  0, 13'h010, 2'b10, 0, 32'h0, 0, 32'h80ADBEEF, 0);
        access("st_w_mis",  1, 13'h012, 2'b10, 0, 32'h55555555, 1, 32'h0, 0);
        access("ld_word4",  0, 13'h010, 2'b10, 0, 32'h0, 0, 32'h80ADBEEF, 0);
        access("st_word0",  1, 13'h000, 2'b10, 0, 32'h11223344, 0, 32'h0, 0);
        access("st_oob",    1, 13'h1000, 2'b10, 0, 32'hCAFEF00D, 1, 32'h0, 0);
        access("ld_word0",  0, 13'h000, 2'b10, 0, 32'h0, 0, 32'h11223344, 0);
        access("ld_oob",    0, 13'h1ffc, 2'b10, 0, 32'h0, 1, 32'h0, 0);
        access("st_word14", 1, 13'h014, 2'b10, 0, 32'h01234567, 0, 32'h0, 0);
        access("st_half16", 1, 13'h016, 2'b01, 0, 32'hFFFFBEEF, 0, 32'h0, 0);
        access("ld_word14", 0, 13'h014, 2'b10, 0, 32'h0, 0, 32'hBEEF4567, 0);
        access("ld_half_s", 0, 13'h016, 2'b01, 1, 32'h0, 0, 32'hFFFFBEEF, 0);
        access("ld_half_u", 0, 13'h014, 2'b01, 0, 32'h0, 0, 32'h00004567, 0);
        access("ld_b14_u",  0, 13'h014, 2'b00, 0, 32'h0, 0, 32'h00000067, 0);
        access("ld_b15_s",  0, 13'h015, 2'b00, 1, 32'h0, 0, 32'h00000045, 0);
        access("ld_b17_s",  0, 13'h017, 2'b00, 1, 32'h0, 0, 32'hFFFFFFBE, 0);
        access("ld_dword",  0, 13'h018, 2'b11, 0, 32'h0, 1, 32'h0, 0);

        sel = 1'b1;
        access("l3_st",     1, 13'h020, 2'b10, 0, 32'h5A5A1234, 0, 32'h0, 0);
        access("l3_ld_hold", 0, 13'h020, 2'b10, 0, 32'h0, 0, 32'h5A5A1234, 5);

        @(negedge clk);
        req_we = 1'b1; req_addr = 13'h024; req_size = 2'b10; req_signed = 1'b0;
        req_wdata = 32'h0BADF00D; req_valid = 1'b1;
        chk("abort_ready", 64'(m_req_ready), 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_rst_valid", 64'(m_resp_valid), 64'd0);
        chk("abort_rst_ready", 64'(m_req_ready), 64'd0);
        chk("abort_rst_data", 64'({m_resp_err, m_resp_rdata}), 64'd0);
        repeat (2) @(negedge clk);
        chk("abort_rst_ready2", 64'(m_req_ready), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_release_ready", 64'(m_req_ready), 64'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_no_resp", 64'(m_resp_valid), 64'd0);
        end
        access("l3_ld_abort", 0, 13'h024, 2'b10, 0, 32'h0, 0, 32'h0BADF00D, 0);
        sel = 1'b0;
        access("ld_after_rst", 0, 13'h010, 2'b10, 0, 32'h0, 0, 32'h80ADBEEF, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
